// File: rtl/onehot_dec_pkg.sv
// Shared definitions for the one-hot decode sequencer: state codes,
// default timing constants and counter widths.
package onehot_dec_pkg;

    // Width of the hold / timeout down-counter.
    localparam int CNT_W = 8;

    // Width of the optional statistics counters.
    localparam int SAT_W = 16;

    // Default timing.
    localparam int HOLD_CYC_DEF = 4;
    localparam int TMO_CYC_DEF  = 16;

    // State codes.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HOLD = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        HOLD = ST_HOLD,
        WAIT = ST_WAIT,
        DONE = ST_DONE,
        ERR  = ST_ERR
    } state_t;

    // Down-counter load value for a phase lasting cyc cycles.
    function automatic logic [CNT_W-1:0] cnt_load(input int cyc);
        return CNT_W'(cyc - 1);
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// Saturating event counter with synchronous clear.
// Ports: clk, rst (async, active-high), clr (sync clear, wins over inc),
//        inc (count one event), q (count, sticks at all-ones).
module sat_counter16
    import onehot_dec_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [SAT_W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {SAT_W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/onehot_decode_sequencer.sv
// Decodes an encoded channel index into a held one-hot line, holds it for a
// minimum time, then waits (bounded) for the target's acknowledge.
// Ports: clk, rst (async, active-high); code_valid/code_ready/code accept an
//   index; line_out one-hot drive; ack target acknowledge; busy, done and
//   tmo_err status (done/tmo_err are one-cycle pulses).
// Optional macro ONEHOT_DEC_STATS_EN adds stats_clr, xfer_cnt and tmo_cnt.
module onehot_decode_sequencer
    import onehot_dec_pkg::*;
#(
    parameter int IDX_W    = 3,
    parameter int HOLD_CYC = HOLD_CYC_DEF,
    parameter int TMO_CYC  = TMO_CYC_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    code_valid,
    output logic                    code_ready,
    input  logic [IDX_W-1:0]        code,
    output logic [(1<<IDX_W)-1:0]   line_out,
    input  logic                    ack,
    output logic                    busy,
    output logic                    done,
`ifdef ONEHOT_DEC_STATS_EN
    input  logic                    stats_clr,
    output logic [SAT_W-1:0]        xfer_cnt,
    output logic [SAT_W-1:0]        tmo_cnt,
`endif
    output logic                    tmo_err
);

    localparam int N = 1 << IDX_W;
    localparam logic [CNT_W-1:0] HOLD_LD = cnt_load(HOLD_CYC);
    localparam logic [CNT_W-1:0] TMO_LD  = cnt_load(TMO_CYC);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [N-1:0]     line_n;
    logic [N-1:0]     lsb_one;

    assign lsb_one = {{(N-1){1'b0}}, 1'b1};

    // line_out itself is the captured index: it is loaded one-hot on the
    // handshake and cleared on the way out, so it never glitches.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        line_n  = line_out;
        unique case (state)
            IDLE: begin
                if (code_valid && code_ready) begin
                    state_n = HOLD;
                    cnt_n   = HOLD_LD;
                    line_n  = lsb_one << code;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_n = WAIT;
                    cnt_n   = TMO_LD;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            WAIT: begin
                // ack takes priority over an expiring timeout
                if (ack) begin
                    state_n = DONE;
                    line_n  = '0;
                end else if (cnt == '0) begin
                    state_n = ERR;
                    line_n  = '0;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DONE, ERR: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                line_n  = '0;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // with the state they describe and come straight off flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            line_out   <= '0;
            code_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            tmo_err    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            line_out   <= line_n;
            code_ready <= (state_n == IDLE);
            busy       <= (state_n != IDLE);
            done       <= (state_n == DONE);
            tmo_err    <= (state_n == ERR);
        end
    end

`ifdef ONEHOT_DEC_STATS_EN
    logic enter_done;
    logic enter_err;

    assign enter_done = (state == WAIT) && (state_n == DONE);
    assign enter_err  = (state == WAIT) && (state_n == ERR);

    sat_counter16 u_xfer_cnt (
        .clk (clk),
        .rst (rst),
        .clr (stats_clr),
        .inc (enter_done),
        .q   (xfer_cnt)
    );

    sat_counter16 u_tmo_cnt (
        .clk (clk),
        .rst (rst),
        .clr (stats_clr),
        .inc (enter_err),
        .q   (tmo_cnt)
    );
`endif

endmodule

// File: tb/tb_onehot_decode_sequencer.sv
// Self-checking bench for onehot_decode_sequencer: directed transactions with
// literal expectations plus randomized traffic against a transaction model.
module tb_onehot_decode_sequencer;

    localparam int H = 4;
    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       code_valid = 1'b0;
    logic [2:0] code = 3'd0;
    logic       ack = 1'b0;
    logic       code_ready;
    logic [7:0] line_out;
    logic       busy;
    logic       done;
    logic       tmo_err;
`ifdef ONEHOT_DEC_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] xfer_cnt;
    logic [15:0] tmo_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    onehot_decode_sequencer #(
        .IDX_W    (3),
        .HOLD_CYC (H),
        .TMO_CYC  (T)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .code       (code),
        .line_out   (line_out),
        .ack        (ack),
        .busy       (busy),
        .done       (done),
`ifdef ONEHOT_DEC_STATS_EN
        .stats_clr  (stats_clr),
        .xfer_cnt   (xfer_cnt),
        .tmo_cnt    (tmo_cnt),
`endif
        .tmo_err    (tmo_err)
    );

    task automatic check(input string nm, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // A transaction is tracked by its age in clock edges since the
    // handshake: ages 1..H are the hold, H+1..H+T are the ack window.
    logic [7:0] m_line = '0;
    logic       m_ready = 1'b0;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic       m_tmo = 1'b0;
    bit         m_act = 0;
    bit         m_post = 0;
    int         m_age = 0;
    int         m_xfer = 0;
    int         m_tmoc = 0;

    initial begin
        forever begin
            bit inc_x;
            bit inc_t;
            @(posedge clk);
            inc_x = 0;
            inc_t = 0;
            if (rst) begin
                m_line = '0; m_ready = 0; m_busy = 0;
                m_done = 0; m_tmo = 0; m_act = 0; m_post = 0;
                m_xfer = 0; m_tmoc = 0;
            end else begin
                if (m_act) begin
                    m_age++;
                    if (m_age > H && (ack || m_age == H + T)) begin
                        m_act = 0; m_post = 1; m_line = '0;
                        m_done = ack; m_tmo = !ack;
                        inc_x = ack; inc_t = !ack;
                    end
                end else if (m_post) begin
                    m_post = 0; m_done = 0; m_tmo = 0;
                    m_ready = 1; m_busy = 0;
                end else if (code_valid && m_ready) begin
                    m_act = 1; m_age = 0;
                    m_line = 8'(1) << code;
                    m_ready = 0; m_busy = 1;
                end else begin
                    m_ready = 1;
                end
`ifdef ONEHOT_DEC_STATS_EN
                if (stats_clr) begin
                    m_xfer = 0; m_tmoc = 0;
                end else begin
                    if (inc_x && m_xfer < 16'hFFFF) m_xfer++;
                    if (inc_t && m_tmoc < 16'hFFFF) m_tmoc++;
                end
`endif
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            check("line_out", int'(line_out), int'(m_line));
            check("code_ready", int'(code_ready), int'(m_ready));
            check("busy", int'(busy), int'(m_busy));
            check("done", int'(done), int'(m_done));
            check("tmo_err", int'(tmo_err), int'(m_tmo));
            check("onehot0", int'($onehot0(line_out)), 1);
`ifdef ONEHOT_DEC_STATS_EN
            check("xfer_cnt", int'(xfer_cnt), m_xfer);
            check("tmo_cnt", int'(tmo_cnt), m_tmoc);
`endif
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed helpers ----------------
    task automatic wait_ready();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (code_ready) return;
        end
        check("wait_ready_timeout", 0, 1);
    endtask

    // Runs one transaction; ack is high during relative cycles af..at
    // (cycle 0 = handshake cycle, cycle 1 = first HOLD cycle).
    task automatic txn(input logic [2:0] c, input int af, input int at,
                       output int line_cyc, output int done_k,
                       output int tmo_k, output int pulses,
                       output int rdy_after);
        logic [7:0] oh;
        int endk;
        oh = 8'(1) << c;
        line_cyc = 0; done_k = -1; tmo_k = -1; pulses = 0; rdy_after = 0;
        endk = 60;
        wait_ready();
        #1;
        code_valid = 1'b1;
        code = c;
        ack = (af <= 0 && at >= 0);
        for (int k = 1; k <= endk; k++) begin
            @(negedge clk);
            if (line_out == oh) line_cyc++;
            if (done) begin
                pulses++;
                if (done_k < 0) begin done_k = k; endk = k + 1; end
            end
            if (tmo_err) begin
                pulses++;
                if (tmo_k < 0) begin tmo_k = k; endk = k + 1; end
            end
            if (k == endk) rdy_after = int'(code_ready);
            #1;
            code_valid = 1'b0;
            ack = (k >= af && k <= at);
        end
        ack = 1'b0;
    endtask

    int lc, dk, tk, pc, ra;
    logic [7:0] lk [0:20];
    logic       rk [0:20];
    int         nrdy;
    int         ackp;

    initial begin
        // reset held with a pending request
        code_valid = 1'b1;
        code = 3'd5;
        repeat (3) begin
            @(negedge clk);
            check("rst_line", int'(line_out), 0);
            check("rst_ready", int'(code_ready), 0);
            check("rst_done", int'(done), 0);
        end
        #1;
        rst = 1'b0;
        code_valid = 1'b0;
        @(negedge clk);
        check("ready_after_rst", int'(code_ready), 1);

        // normal: ack in the 2nd WAIT cycle
        txn(3'd3, H + 2, H + 2, lc, dk, tk, pc, ra);
        check("norm_line_cycles", lc, 6);
        check("norm_done_cycle", dk, 7);
        check("norm_no_tmo", tk, -1);
        check("norm_pulse_width", pc, 1);
        check("norm_ready_back", ra, 1);

        // timeout
        txn(3'd7, 99, 0, lc, dk, tk, pc, ra);
        check("tmo_line_cycles", lc, 20);
        check("tmo_err_cycle", tk, 21);
        check("tmo_no_done", dk, -1);
        check("tmo_pulse_width", pc, 1);

        // ack held from the handshake: ignored during HOLD
        txn(3'd0, 0, 60, lc, dk, tk, pc, ra);
        check("ackheld_done_cycle", dk, 6);
        check("ackheld_line_cycles", lc, 5);

        // ack on the last WAIT cycle wins over timeout
        txn(3'd2, H + T, H + T, lc, dk, tk, pc, ra);
        check("lastwait_done_cycle", dk, 21);
        check("lastwait_no_tmo", tk, -1);
        check("lastwait_line_cycles", lc, 20);

        // back-to-back with code_valid held high
        wait_ready();
        #1;
        code_valid = 1'b1;
        code = 3'd1;
        ack = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            lk[k] = line_out;
            rk[k] = code_ready;
            #1;
            if (k == 1) code = 3'd6;
            if (k == 8) code_valid = 1'b0;
            ack = (k == 5 || k == 12);
        end
        ack = 1'b0;
        nrdy = 0;
        for (int k = 1; k <= 8; k++) nrdy += int'(rk[k]);
        check("b2b_first_line", int'(lk[5]), 8'h02);
        check("b2b_done_gap", int'(lk[6]), 0);
        check("b2b_idle_ready", int'(rk[7]), 1);
        check("b2b_idle_line", int'(lk[7]), 0);
        check("b2b_second_line", int'(lk[8]), 8'h40);
        check("b2b_idle_count", nrdy, 1);
        check("b2b_second_end", int'(lk[13]), 0);

        // reset pulsed mid-HOLD
        wait_ready();
        #1;
        code_valid = 1'b1;
        code = 3'd4;
        @(negedge clk);
        check("midrst_line_before", int'(line_out), 8'h10);
        #1;
        code_valid = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_line_cleared", int'(line_out), 0);
        check("midrst_busy", int'(busy), 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_done", int'(done), 0);
            check("midrst_no_tmo", int'(tmo_err), 0);
        end

        // randomized traffic
        ackp = 30;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            #1;
            if (cyc % 250 == 0) begin
                case ($urandom % 4)
                    0: ackp = 0;
                    1: ackp = 5;
                    2: ackp = 30;
                    default: ackp = 100;
                endcase
            end
            code_valid = 1'($urandom % 2);
            code = 3'($urandom);
            ack = (int'($urandom % 100) < ackp);
            rst = ($urandom % 600 == 0);
`ifdef ONEHOT_DEC_STATS_EN
            stats_clr = ($urandom % 150 == 0);
`endif
        end
        #1;
        rst = 1'b0;
        code_valid = 1'b0;
        ack = 1'b0;
`ifdef ONEHOT_DEC_STATS_EN
        stats_clr = 1'b0;
        // statistics: 3 acked, 2 timed out, then clear
        @(negedge clk);
        #1;
        stats_clr = 1'b1;
        @(negedge clk);
        #1;
        stats_clr = 1'b0;
        repeat (3) txn(3'($urandom), H + 1, H + 3, lc, dk, tk, pc, ra);
        repeat (2) txn(3'($urandom), 99, 0, lc, dk, tk, pc, ra);
        @(negedge clk);
        check("stats_xfer_3", int'(xfer_cnt), 3);
        check("stats_tmo_2", int'(tmo_cnt), 2);
        #1;
        stats_clr = 1'b1;
        @(negedge clk);
        #1;
        stats_clr = 1'b0;
        @(negedge clk);
        check("stats_xfer_clr", int'(xfer_cnt), 0);
        check("stats_tmo_clr", int'(tmo_cnt), 0);
`endif
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
